// File: rtl/register_bank_if.sv
// Bus interface for register_bank: two read ports, one write port.
//   read      - read request, both read ports sample together
//   write     - write request
//   addr_r1/2 - read port register indices
//   addr_w    - write port register index
//   data_w    - write data
//   data_r1/2 - registered read data
//   rd_valid  - high the cycle after each accepted read
interface register_bank_if #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_INDEX_WIDTH = 5
);

  logic                        read;
  logic                        write;
  logic [ADDR_INDEX_WIDTH-1:0] addr_r1;
  logic [ADDR_INDEX_WIDTH-1:0] addr_r2;
  logic [ADDR_INDEX_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0]       data_w;
  logic [DATA_WIDTH-1:0]       data_r1;
  logic [DATA_WIDTH-1:0]       data_r2;
  logic                        rd_valid;

  modport master (
    output read, write, addr_r1, addr_r2, addr_w, data_w,
    input  data_r1, data_r2, rd_valid
  );

  modport slave (
    input  read, write, addr_r1, addr_r2, addr_w, data_w,
    output data_r1, data_r2, rd_valid
  );

endinterface

// File: rtl/register_bank.sv
// Register bank: 2**ADDR_INDEX_WIDTH registers, two registered read ports and
// one write port. Register 0 is hardwired to zero. A read and a write to the
// same nonzero index in one cycle return the new write data (write-first).
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - register_bank_if slave modport (requests in, read data out)
module register_bank #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_INDEX_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  register_bank_if.slave bus
);

  localparam int unsigned NUM_REGS = 1 << ADDR_INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd1_c;
  logic [DATA_WIDTH-1:0] rd2_c;
  logic                  wr_en_c;

  // Index 0 is never written, so regs[0] stays at its reset value of zero.
  assign wr_en_c = bus.write && (bus.addr_w != '0);

  // Read mux with write-first bypass; the bypass never fires for index 0.
  always_comb begin
    rd1_c = regs[bus.addr_r1];
    rd2_c = regs[bus.addr_r2];
    if (wr_en_c && (bus.addr_w == bus.addr_r1)) rd1_c = bus.data_w;
    if (wr_en_c && (bus.addr_w == bus.addr_r2)) rd2_c = bus.data_w;
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (wr_en_c) begin
      regs[bus.addr_w] <= bus.data_w;
    end
  end

  // Registered read outputs; data holds when no read is requested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_r1  <= '0;
      bus.data_r2  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.read;
      if (bus.read) begin
        bus.data_r1 <= rd1_c;
        bus.data_r2 <= rd2_c;
      end
    end
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_WIDTH, 32: width of each register and of every data port.
REQ-002 Parameter ADDR_INDEX_WIDTH, 5: register index width; the bank holds 2**ADDR_INDEX_WIDTH (32) registers.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 READ  input  1  read request; both read ports sample in the same cycle.
REQ-007 WRITE  input  1  write request for the write port.
REQ-008 ADDR_R1  input  5  read port 1 register index.
REQ-009 ADDR_R2  input  5  read port 2 register index.
REQ-010 ADDR_W  input  5  write port register index.
REQ-011 DATA_W  input  32  write data.
REQ-012 DATA_R1  output  32  registered read data, port 1.
REQ-013 DATA_R2  output  32  registered read data, port 2.
REQ-014 RD_VALID  output  1  high for exactly the cycle after each accepted read.

Function
REQ-015 Storage: 32 x 32-bit registers; the downstream 32x1 word-select mux is built in, driven by ADDR_R1/ADDR_R2.
REQ-016 Write: at a rising CLK with WRITE=1 and ADDR_W!=0, register[ADDR_W] <= DATA_W; visible to reads from the next edge.
REQ-017 Register 0 reads as 0 always; writes to index 0 are discarded with no other side effect.
REQ-018 Read: at a rising CLK with READ=1, DATA_R1 <= register[ADDR_R1] and DATA_R2 <= register[ADDR_R2]; latency one cycle.
REQ-019 RD_VALID <= READ at every rising edge; with back-to-back READ it stays high continuously.
REQ-020 With READ=0, DATA_R1/DATA_R2 hold their last value; no X or zero fill.
REQ-021 Simultaneous READ and WRITE to the same nonzero index: the read returns DATA_W (write-first bypass), per port independently.
REQ-022 Simultaneous READ and WRITE with ADDR_W=0: the read of index 0 returns 0, never DATA_W.
REQ-023 ADDR_R1==ADDR_R2 is legal; both ports return identical data.
REQ-024 WRITE with no READ leaves DATA_R1, DATA_R2 and RD_VALID unchanged or low as per REQ-019/020.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 RST low, asynchronously and independent of CLK: all 32 registers, DATA_R1, DATA_R2 = 32'h0; RD_VALID = 0.
REQ-027 Reset asserted mid-operation overrides any READ/WRITE at the same edge; the pending write is lost.
REQ-028 After RST deasserts, the first rising edge with READ/WRITE is honored normally.

Verification
REQ-029 Reset, then READ with ADDR_R1=5, ADDR_R2=31 -> next cycle DATA_R1=0, DATA_R2=0, RD_VALID=1.
REQ-030 WRITE ADDR_W=7, DATA_W=32'hDEADBEEF; next cycle READ ADDR_R1=7 -> DATA_R1=32'hDEADBEEF one cycle later.
REQ-031 WRITE ADDR_W=0, DATA_W=32'hFFFFFFFF with READ ADDR_R1=0, then READ again -> DATA_R1=0 both times.
REQ-032 Same edge WRITE ADDR_W=3, DATA_W=32'h12345678 and READ ADDR_R1=3, ADDR_R2=4 (reg4=32'hA5A5A5A5) -> DATA_R1=32'h12345678, DATA_R2=32'hA5A5A5A5.
REQ-033 Write distinct values to all 31 nonzero indices, read each pair (i, 31-i) -> every port returns the value written; then READ=0 for 3 cycles -> outputs hold, RD_VALID=0.
REQ-034 Assert RST between CLK edges after registers are populated -> outputs 0 immediately; subsequent reads of any index return 0.
